mul8s_iter_sched: RTL and testbench

- Iterative 8x8 signed multiplier built around one shared 4x4 partial-product unit.
- The sequencer issues the four nibble products (LL, LH, HL, HH) to that unit one per cycle, selecting the signed/unsigned mode and shift for each, and accumulates them into an exact 16-bit two's-complement product.
- Area-saving alternative to the fully parallel 8x8 signed multiplier; same arithmetic result; valid/ready stream interfaces on both sides.

---
 rtl/mul8s_sched_pkg.sv | 38 +++
 rtl/mul8s_iter_sched_mul4.sv | 35 +++
 rtl/mul8s_iter_sched.sv | 142 ++++++++++++++
 tb/tb_mul8s_iter_sched.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul8s_sched_pkg.sv
// Shared types and constants for the iterative 8x8 signed multiplier:
// sequencer states, per-step signedness modes and shifts.
package mul8s_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LL    = 3'd1,
    S_LH    = 3'd2,
    S_HL    = 3'd3,
    S_HH    = 3'd4,
    S_DRAIN = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  localparam int PROD_W = 16;
  localparam int PP_W   = 9;

  // Mode is {x_signed, y_signed}; x is the a-nibble, y the b-nibble.
  localparam logic [1:0] MODE_UU = 2'b00;
  localparam logic [1:0] MODE_US = 2'b01;
  localparam logic [1:0] MODE_SU = 2'b10;
  localparam logic [1:0] MODE_SS = 2'b11;

  localparam logic [3:0] SHIFT_LL = 4'd0;
  localparam logic [3:0] SHIFT_LH = 4'd4;
  localparam logic [3:0] SHIFT_HL = 4'd4;
  localparam logic [3:0] SHIFT_HH = 4'd8;

  // Unsigned-by-unsigned results never set bit 8, so sign extension is
  // also the correct zero extension for that mode.
  function automatic logic [PROD_W-1:0] align_pp(input logic [PP_W-1:0] pp,
                                                 input logic [3:0] sh);
    logic [PROD_W-1:0] ext;
    ext = {{(PROD_W-PP_W){pp[PP_W-1]}}, pp};
    return ext << sh;
  endfunction

endpackage

// File: rtl/mul8s_iter_sched_mul4.sv
// 4x4 partial-product unit with per-operand signedness; 9-bit signed result,
// optionally registered when MUL4_LAT=1.
module mul4_ssu
  import mul8s_sched_pkg::*;
#(
  parameter int MUL4_LAT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      x,
  input  logic [3:0]      y,
  input  logic            x_signed,
  input  logic            y_signed,
  output logic [PP_W-1:0] pp
);

  logic signed [9:0] xw;
  logic signed [9:0] yw;
  logic signed [9:0] full;
  logic [PP_W-1:0]   pp_c;
  logic [PP_W-1:0]   pp_q;

  assign xw   = {{6{x_signed & x[3]}}, x};
  assign yw   = {{6{y_signed & y[3]}}, y};
  assign full = xw * yw;
  assign pp_c = full[PP_W-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pp_q <= '0;
    else        pp_q <= pp_c;
  end

  assign pp = (MUL4_LAT == 0) ? pp_c : pp_q;

endmodule

// File: rtl/mul8s_iter_sched.sv
// Iterative 8x8 signed multiplier: four nibble products issued one per cycle
// to a shared 4x4 unit and accumulated into a 16-bit product.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds data stable while valid is high and ready is low.
module mul8s_iter_sched
  import mul8s_sched_pkg::*;
#(
  parameter int MUL4_LAT = 0,
  parameter int CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [7:0]        in_a,
  input  logic [7:0]        in_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [15:0]       out_product,
  output logic              busy,
  output logic [CNT_W-1:0]  op_count
);

  state_t            state;
  state_t            state_next;
  logic [7:0]        a_q;
  logic [7:0]        b_q;
  logic [PROD_W-1:0] acc;
  logic [PROD_W-1:0] acc_next;

  logic              issue;
  logic [3:0]        issue_shift;
  logic [1:0]        mode;
  logic [3:0]        x_sel;
  logic [3:0]        y_sel;
  logic [PP_W-1:0]   pp;

  logic              issue_q;
  logic [3:0]        shift_q;
  logic              acc_en;
  logic [3:0]        acc_shift;

  logic              in_fire;
  logic              out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;
  assign busy     = (state != S_IDLE);

  always_comb begin
    issue       = 1'b1;
    x_sel       = a_q[3:0];
    y_sel       = b_q[3:0];
    mode        = MODE_UU;
    issue_shift = SHIFT_LL;
    case (state)
      S_LL: ;
      S_LH: begin
        y_sel       = b_q[7:4];
        mode        = MODE_US;
        issue_shift = SHIFT_LH;
      end
      S_HL: begin
        x_sel       = a_q[7:4];
        mode        = MODE_SU;
        issue_shift = SHIFT_HL;
      end
      S_HH: begin
        x_sel       = a_q[7:4];
        y_sel       = b_q[7:4];
        mode        = MODE_SS;
        issue_shift = SHIFT_HH;
      end
      default: issue = 1'b0;
    endcase
  end

  mul4_ssu #(.MUL4_LAT(MUL4_LAT)) u_mul4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .x        (x_sel),
    .y        (y_sel),
    .x_signed (mode[1]),
    .y_signed (mode[0]),
    .pp       (pp)
  );

  // With a registered unit the step's shift travels alongside the product,
  // so accumulation lags issue by one cycle.
  assign acc_en    = (MUL4_LAT == 0) ? issue       : issue_q;
  assign acc_shift = (MUL4_LAT == 0) ? issue_shift : shift_q;

  always_comb begin
    acc_next = acc;
    if (in_fire)     acc_next = '0;
    else if (acc_en) acc_next = acc + align_pp(pp, acc_shift);
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_fire) state_next = S_LL;
      S_LL:    state_next = S_LH;
      S_LH:    state_next = S_HL;
      S_HL:    state_next = S_HH;
      S_HH:    state_next = (MUL4_LAT == 0) ? S_DONE : S_DRAIN;
      S_DRAIN: state_next = S_DONE;
      S_DONE:  if (out_fire) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_product <= '0;
      op_count    <= '0;
      acc         <= '0;
      a_q         <= '0;
      b_q         <= '0;
      issue_q     <= 1'b0;
      shift_q     <= '0;
    end else begin
      state     <= state_next;
      in_ready  <= (state_next == S_IDLE);
      out_valid <= (state_next == S_DONE);
      acc       <= acc_next;
      issue_q   <= issue;
      shift_q   <= issue_shift;
      if (in_fire) begin
        a_q <= in_a;
        b_q <= in_b;
      end
      // Result is captured only on entry to DONE and then held.
      if (state_next == S_DONE && state != S_DONE) out_product <= acc_next;
      if (out_fire) op_count <= op_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mul8s_iter_sched.sv
// Bench for mul8s_iter_sched: a combinational-unit instance with directed
// vectors and a registered-unit, 4-bit-counter instance with a corner sweep.
module tb_mul8s_iter_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  // instance 0: MUL4_LAT=0, CNT_W=16
  logic        rst0_n, in_valid0, in_ready0, out_valid0, out_ready0, busy0;
  logic [7:0]  in_a0, in_b0;
  logic [15:0] out_product0;
  logic [15:0] op_count0;

  // instance 1: MUL4_LAT=1, CNT_W=4
  logic        rst1_n, in_valid1, in_ready1, out_valid1, out_ready1, busy1;
  logic [7:0]  in_a1, in_b1;
  logic [15:0] out_product1;
  logic [3:0]  op_count1;

  mul8s_iter_sched #(.MUL4_LAT(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst0_n), .in_valid(in_valid0), .in_ready(in_ready0),
    .in_a(in_a0), .in_b(in_b0), .out_valid(out_valid0), .out_ready(out_ready0),
    .out_product(out_product0), .busy(busy0), .op_count(op_count0)
  );

  mul8s_iter_sched #(.MUL4_LAT(1), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst1_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .out_valid(out_valid1), .out_ready(out_ready1),
    .out_product(out_product1), .busy(busy1), .op_count(op_count1)
  );

  logic [15:0] exp_q0[$];
  logic [15:0] exp_q1[$];
  int          acc_q0[$];
  int          acc_q1[$];
  int          cnt0 = 0, cnt1 = 0;
  int          hs_edge0 = 0, acc_last0 = 0;
  int          e0, e1;
  logic        ov_prev0 = 1'b0, ov_prev1 = 1'b0;
  logic        rnd_ready_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst0_n === 1'b1) begin
      if (in_valid0 && in_ready0) begin
        acc_q0.push_back(cyc + 1);
        acc_last0 = cyc + 1;
      end
      if (out_valid0 && !ov_prev0) begin
        if (acc_q0.size() != 0) begin
          e0 = acc_q0.pop_front();
          check("lat0", cyc - e0, 4);
        end else fail("lat0_no_accept");
      end
      if (out_valid0 && out_ready0) begin
        if (exp_q0.size() != 0) check("prod0", out_product0, exp_q0.pop_front());
        else fail("prod0_unexpected");
        check("opcnt0", op_count0, cnt0);
        cnt0++;
        hs_edge0 = cyc + 1;
      end
    end
    ov_prev0 = out_valid0;
  end

  always @(negedge clk) begin
    if (rst1_n === 1'b1) begin
      if (in_valid1 && in_ready1) acc_q1.push_back(cyc + 1);
      if (out_valid1 && !ov_prev1) begin
        if (acc_q1.size() != 0) begin
          e1 = acc_q1.pop_front();
          check("lat1", cyc - e1, 5);
        end else fail("lat1_no_accept");
      end
      if (out_valid1 && out_ready1) begin
        if (exp_q1.size() != 0) check("prod1", out_product1, exp_q1.pop_front());
        else fail("prod1_unexpected");
        check("opcnt1", op_count1, cnt1 % 16);
        cnt1++;
      end
    end
    ov_prev1 = out_valid1;
  end

  always @(posedge clk) begin
    #2;
    if (rnd_ready_en) out_ready1 = ($urandom_range(0, 3) != 0);
  end

  // ---------------- drivers ----------------
  task automatic wait_in0();
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready0) break;
    end
    if (k == 50) fail("in_ready0_timeout");
  endtask

  task automatic wait_drain0();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q0.size() == 0) break;
    end
    if (k == 100) fail("drain0_timeout");
    @(posedge clk);
  endtask

  task automatic run0(input logic [7:0] a, input logic [7:0] b, input logic [15:0] exp);
    @(posedge clk); #2;
    in_valid0 = 1'b1; in_a0 = a; in_b0 = b;
    exp_q0.push_back(exp);
    wait_in0();
    @(posedge clk); #2;
    in_valid0 = 1'b0;
    wait_drain0();
  endtask

  task automatic run1(input logic [7:0] a, input logic [7:0] b);
    logic signed [7:0]  sa, sb;
    logic signed [15:0] p;
    int k;
    sa = a; sb = b;
    p  = 16'(sa) * 16'(sb);
    @(posedge clk); #2;
    in_valid1 = 1'b1; in_a1 = a; in_b1 = b;
    exp_q1.push_back(p);
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready1) break;
    end
    if (k == 50) fail("in_ready1_timeout");
    @(posedge clk); #2;
    in_valid1 = 1'b0;
    for (k = 0; k < 400; k++) begin
      @(negedge clk);
      if (exp_q1.size() == 0) break;
    end
    if (k == 400) fail("drain1_timeout");
    @(posedge clk);
  endtask

  task automatic seq0();
    int k;
    rst0_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst0_in_ready", in_ready0, 0);
    check("rst0_out_valid", out_valid0, 0);
    check("rst0_product", out_product0, 0);
    check("rst0_busy", busy0, 0);
    check("rst0_opcnt", op_count0, 0);
    @(negedge clk); rst0_n = 1'b1;
    @(posedge clk); #1;
    check("rst0_in_ready_rise", in_ready0, 1);

    run0(8'h80, 8'h80, 16'h4000);
    @(negedge clk);
    check("opcnt0_first", op_count0, 1);
    run0(8'h7F, 8'h80, 16'hC080);
    run0(8'hFF, 8'h01, 16'hFFFF);
    run0(8'h00, 8'h9C, 16'h0000);

    // backpressure: 0x12 * 0xF3 = 18 * -13 = -234
    @(posedge clk); #2;
    out_ready0 = 1'b0;
    in_valid0 = 1'b1; in_a0 = 8'h12; in_b0 = 8'hF3;
    exp_q0.push_back(16'hFF16);
    wait_in0();
    @(posedge clk); #2;
    in_a0 = 8'h55; in_b0 = 8'h55;
    exp_q0.push_back(16'h1C39);
    for (k = 0; k < 20; k++) begin
      @(negedge clk);
      if (out_valid0) break;
    end
    if (k == 20) fail("bp_valid_timeout");
    repeat (10) begin
      @(negedge clk);
      check("bp_hold_valid", out_valid0, 1);
      check("bp_hold_prod", out_product0, 16'hFF16);
      check("bp_in_ready", in_ready0, 0);
    end
    @(posedge clk); #2;
    out_ready0 = 1'b1;
    wait_in0();
    @(posedge clk); #2;
    in_valid0 = 1'b0;
    check("bp_accept_gap", acc_last0 - hs_edge0, 1);
    wait_drain0();
    @(negedge clk);
    check("bp_product_kept", out_product0, 16'h1C39);

    // reset while the sequencer is in HL
    @(posedge clk); #2;
    in_valid0 = 1'b1; in_a0 = 8'h21; in_b0 = 8'h34;
    wait_in0();
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    in_valid0 = 1'b0;
    check("mid_busy_pre", busy0, 1);
    rst0_n = 1'b0;
    #1;
    check("mid_out_valid", out_valid0, 0);
    check("mid_busy", busy0, 0);
    check("mid_opcnt", op_count0, 0);
    check("mid_in_ready", in_ready0, 0);
    check("mid_product", out_product0, 0);
    exp_q0.delete();
    acc_q0.delete();
    cnt0 = 0;
    @(negedge clk); rst0_n = 1'b1;
    @(posedge clk); #1;
    check("mid_in_ready_rise", in_ready0, 1);
    run0(8'h03, 8'hFD, 16'hFFF7);
  endtask

  task automatic seq1();
    logic [7:0] vals [16];
    int n;
    vals = '{8'h00, 8'h01, 8'h02, 8'h07, 8'h08, 8'h0F, 8'h10, 8'h3C,
             8'h7F, 8'h80, 8'h81, 8'hAA, 8'hC3, 8'hF0, 8'hF8, 8'hFF};
    rst1_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst1_in_ready", in_ready1, 0);
    check("rst1_opcnt", op_count1, 0);
    @(negedge clk); rst1_n = 1'b1;
    @(posedge clk); #1;
    check("rst1_in_ready_rise", in_ready1, 1);
    rnd_ready_en = 1'b1;
    n = 0;
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < 16; j++) begin
        run1(vals[i], vals[j]);
        n++;
        if (n == 15) check("cnt_wrap_15", op_count1, 4'hF);
        if (n == 16) check("cnt_wrap_16", op_count1, 4'h0);
        if (n == 17) check("cnt_wrap_17", op_count1, 4'h1);
      end
    end
  endtask

  initial begin
    rst0_n = 1'b1; rst1_n = 1'b1;
    in_valid0 = 1'b0; in_a0 = '0; in_b0 = '0; out_ready0 = 1'b1;
    in_valid1 = 1'b0; in_a1 = '0; in_b1 = '0; out_ready1 = 1'b1;
    #1;
    fork
      seq0();
      seq1();
    join
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("q0_empty", exp_q0.size(), 0);
    check("q1_empty", exp_q1.size(), 0);
    check("opcnt1_final", op_count1, cnt1 % 16);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    fail("watchdog");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
